// File: rtl/alarm_annunciator.sv
// Alarm annunciator: turns the security-FSM status word into siren and LED
// drive. It provides an entry-delay countdown, a siren timeout, user silence
// and a saturating count of siren activations.
// Optional build macro SIREN_PULSE_EN: when defined, the siren is pulsed at
// the blink rate instead of being driven steadily.
module alarm_annunciator #(
    parameter int DELAY_CYC = 16,
    parameter int SIREN_CYC = 64,
    parameter int BLINK_DIV = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] status_i,
    input  logic       silence_i,
    output logic       siren_o,
    output logic       led_power_o,
    output logic       led_armed_o,
    output logic       led_alert_o,
    output logic [3:0] alarm_count_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREALARM = 3'd1;
    localparam logic [2:0] S_SIREN    = 3'd2;
    localparam logic [2:0] S_HOLDOFF  = 3'd3;
    localparam logic [2:0] S_CHIME    = 3'd4;

    localparam int               BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]         statMeta_q;
    logic [2:0]         statSync_q;
    logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
    logic               blinkPhase_q, blinkPhase_d;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         alarmCnt_q, alarmCnt_d;

    logic pwr;
    logic arm;
    logic trg;

    assign pwr = statSync_q[2];
    assign arm = statSync_q[1];
    assign trg = statSync_q[0];

    // Two-flop resynchroniser for the asynchronous status word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statMeta_q <= 3'b000;
            statSync_q <= 3'b000;
        end else begin
            statMeta_q <= status_i;
            statSync_q <= statMeta_q;
        end
    end

    // Free-running blink divider; phase flips each time the divider wraps.
    always_comb begin
        blinkCnt_d   = blinkCnt_q + BLINK_W'(1);
        blinkPhase_d = blinkPhase_q;
        if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
        end
    end

    // Next-state logic: power loss overrides everything, then per-state rules.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alarmCnt_d = alarmCnt_q;
        if (!pwr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trg && arm) begin
                        state_d = S_PREALARM;
                        cnt_d   = DELAY_LOAD;
                    end else if (trg) begin
                        state_d = S_CHIME;
                    end
                end
                S_PREALARM: begin
                    if (!trg) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = S_SIREN;
                        cnt_d   = SIREN_LOAD;
                        if (alarmCnt_q != 4'hF) begin
                            alarmCnt_d = alarmCnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_SIREN: begin
                    if (!trg) begin
                        state_d = S_IDLE;
                    end else if (silence_i || (cnt_q == '0)) begin
                        state_d = S_HOLDOFF;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_HOLDOFF: begin
                    if (!trg) begin
                        state_d = S_IDLE;
                    end
                end
                S_CHIME: begin
                    if (!trg) begin
                        state_d = S_IDLE;
                    end else if (arm) begin
                        state_d = S_PREALARM;
                        cnt_d   = DELAY_LOAD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, shared down-counter, event counter and blink registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alarmCnt_q   <= 4'd0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alarmCnt_q   <= alarmCnt_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
`ifdef SIREN_PULSE_EN
        siren_o = (state_q == S_SIREN) && blinkPhase_q;
`else
        siren_o = (state_q == S_SIREN);
`endif
        case (state_q)
            S_PREALARM, S_CHIME: led_alert_o = blinkPhase_q;
            S_SIREN, S_HOLDOFF:  led_alert_o = 1'b1;
            default:             led_alert_o = 1'b0;
        endcase
    end

    assign led_power_o   = pwr;
    assign led_armed_o   = arm;
    assign alarm_count_o = alarmCnt_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Self-checking bench for alarm_annunciator: a table of single-cycle vectors
// for power-up and chime behaviour, then hand-written multi-cycle sequences
// for the entry delay, siren timeout, silence, abort, saturation and reset.
module tb_alarm_annunciator;

    localparam int DELAY_CYC = 16;
    localparam int SIREN_CYC = 64;
    localparam int BLINK_DIV = 4;
    localparam int CNT_W     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] status;
    logic       silence;
    logic       siren;
    logic       ledPower;
    logic       ledArmed;
    logic       ledAlert;
    logic [3:0] alarmCount;

    typedef struct {
        logic [2:0] status;
        logic       silence;
        logic       expSiren;
        logic       expPower;
        logic       expArmed;
        logic       expAlert;
        logic [3:0] expCount;
    } vec_t;

    vec_t       vecs [24];
    int         testsRun    = 0;
    int         testsFailed = 0;
    int         edgeNum     = 0;
    logic [3:0] expCount    = 4'd0;

    alarm_annunciator #(
        .DELAY_CYC(DELAY_CYC),
        .SIREN_CYC(SIREN_CYC),
        .BLINK_DIV(BLINK_DIV),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .status_i(status),
        .silence_i(silence),
        .siren_o(siren),
        .led_power_o(ledPower),
        .led_armed_o(ledArmed),
        .led_alert_o(ledAlert),
        .alarm_count_o(alarmCount)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Expected blink phase after a given edge counted from reset release.
    function automatic logic blinkAt(input int e);
        return ((e / BLINK_DIV) % 2) == 1;
    endfunction

    // Expected siren level while in the siren state.
    function automatic logic sirenOn();
`ifdef SIREN_PULSE_EN
        return blinkAt(edgeNum);
`else
        return 1'b1;
`endif
    endfunction

    // Drive inputs, advance one clock edge, then settle before sampling.
    task automatic applyStimulus(input logic [2:0] st, input logic sil);
        status  = st;
        silence = sil;
        @(posedge clk);
        edgeNum++;
        #1;
    endtask

    // Compare every output against the expected values.
    task automatic checkOutput(input string name, input logic eSiren, input logic ePower,
                               input logic eArmed, input logic eAlert, input logic [3:0] eCount);
        testsRun++;
        if (siren !== eSiren || ledPower !== ePower || ledArmed !== eArmed ||
            ledAlert !== eAlert || alarmCount !== eCount) begin
            testsFailed++;
            $display("[TB] FAIL %s edge %0d: got siren=%b power=%b armed=%b alert=%b count=%0d, expected siren=%b power=%b armed=%b alert=%b count=%0d",
                     name, edgeNum, siren, ledPower, ledArmed, ledAlert, alarmCount,
                     eSiren, ePower, eArmed, eAlert, eCount);
        end
    endtask

    // Hold an armed trigger from IDLE until the siren starts.
    task automatic triggerToSiren(input string name);
        for (int k = 0; k <= 18; k++) begin
            applyStimulus(3'b111, 1'b0);
            if (k == 18) begin
                expCount = (expCount == 4'd15) ? 4'd15 : expCount + 4'd1;
                checkOutput(name, sirenOn(), 1'b1, 1'b1, 1'b1, expCount);
            end else begin
                checkOutput(name, 1'b0, 1'b1, 1'b1, (k < 2) ? 1'b0 : blinkAt(edgeNum), expCount);
            end
        end
    endtask

    // Clear the trigger from SIREN/HOLDOFF; IDLE is reached on the third edge.
    task automatic releaseToIdle(input string name);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'b110, 1'b0);
            if (k < 2) checkOutput(name, 1'b0, 1'b1, 1'b1, 1'b1, expCount);
            else       checkOutput(name, 1'b0, 1'b1, 1'b1, 1'b0, expCount);
        end
    endtask

    initial begin
        // Power-up then unlocked trigger (chime) then power loss.
        vecs[0]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        for (int i = 1; i < 10; i++) vecs[i] = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[10] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[11] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[12] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[13] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[14] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[15] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[16] = '{3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[17] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[18] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[19] = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[20] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[21] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[22] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[23] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        status  = 3'b000;
        silence = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        rst_n   = 1'b1;
        edgeNum = 0;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].status, vecs[i].silence);
            checkOutput($sformatf("vec%0d", i), vecs[i].expSiren, vecs[i].expPower,
                        vecs[i].expArmed, vecs[i].expAlert, vecs[i].expCount);
        end

        // Armed and powered, idle.
        for (int k = 0; k < 3; k++) applyStimulus(3'b110, 1'b0);
        checkOutput("armedIdle", 1'b0, 1'b1, 1'b1, 1'b0, expCount);

        // Entry delay then full-length siren ending in HOLDOFF.
        triggerToSiren("delay");
        for (int k = 19; k <= 82; k++) begin
            applyStimulus(3'b111, 1'b0);
            checkOutput("sirenTimeout", (k <= 81) ? sirenOn() : 1'b0, 1'b1, 1'b1, 1'b1, expCount);
        end
        releaseToIdle("releaseA");

        // Code entered during the entry delay: no siren, count unchanged.
        for (int k = 0; k < 38; k++) begin
            applyStimulus((k < 8) ? 3'b111 : 3'b110, 1'b0);
            checkOutput("abort", 1'b0, 1'b1, 1'b1,
                        (k >= 2 && k <= 9) ? blinkAt(edgeNum) : 1'b0, expCount);
        end

        // User silence during the siren.
        triggerToSiren("silenceArm");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b111, 1'b0);
            checkOutput("sirenOn", sirenOn(), 1'b1, 1'b1, 1'b1, expCount);
        end
        applyStimulus(3'b111, 1'b1);
        checkOutput("silenced", 1'b0, 1'b1, 1'b1, 1'b1, expCount);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b111, (k == 2));
            checkOutput("holdoff", 1'b0, 1'b1, 1'b1, 1'b1, expCount);
        end
        releaseToIdle("releaseC");

        // Repeated activations saturate the event counter at 15.
        for (int i = 0; i < 15; i++) begin
            triggerToSiren($sformatf("sat%0d", i));
            applyStimulus(3'b111, 1'b1);
            checkOutput("satSilence", 1'b0, 1'b1, 1'b1, 1'b1, expCount);
            releaseToIdle("satRelease");
        end
        checkOutput("saturated", 1'b0, 1'b1, 1'b1, 1'b0, 4'd15);

        // Asynchronous reset in the middle of a siren.
        triggerToSiren("preReset");
        applyStimulus(3'b111, 1'b0);
        checkOutput("preReset", sirenOn(), 1'b1, 1'b1, 1'b1, expCount);
        #2;
        rst_n = 1'b0;
        #1;
        expCount = 4'd0;
        checkOutput("asyncReset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        edgeNum = 0;
        applyStimulus(3'b100, 1'b0);
        checkOutput("postReset1", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(3'b100, 1'b0);
        checkOutput("postReset2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alarm_annunciator.md
Name: alarm_annunciator

Overview:
- Downstream stage of the security-system FSM.
- Consumes its 3-bit status word Z[2] = power on, Z[1] = locked, Z[0] = triggered.
- Drives siren and indicator LEDs: entry-delay countdown, siren timeout, user silence, alarm-event counter.
- Single clock domain; status_i is treated as asynchronous and resynchronised internally.

Parameters:
- DELAY_CYC, 16: entry-delay length in clk cycles (armed + triggered, before siren); legal range 1..2^CNT_W.
- SIREN_CYC, 64: maximum siren-on duration in cycles; legal range 1..2^CNT_W.
- BLINK_DIV, 4: LED blink half-period in cycles; must be ≥1.
- CNT_W, 8: width of the shared delay/siren down-counter.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- status_i, input, 3: status word from the security FSM {power, locked, triggered}.
- silence_i, input, 1: user silence request, synchronous to clk, level-sampled.
- siren_o, input-driven output, 1: siren drive.
- led_power_o, output, 1: copy of synchronised status bit 2.
- led_armed_o, output, 1: copy of synchronised status bit 1.
- led_alert_o, output, 1: alert indicator (blinking or steady).
- alarm_count_o, output, 4: count of siren activations, saturating at 15.

Behaviour:
Reset (rst_n=0, async):
- State = IDLE; synchroniser flops, counter, blink divider and blink phase = 0.
- All outputs = 0, including alarm_count_o.

Synchroniser:
- status_i passes through 2 flops to give stat_s. Define pwr = stat_s[2], arm = stat_s[1], trg = stat_s[0].
- led_power_o = pwr and led_armed_o = arm, combinational from stat_s, i.e. 2 edges of latency.

Blink divider:
- Free-running; counts 0..BLINK_DIV-1 and toggles blink phase on wrap.
- First toggle occurs at edge BLINK_DIV after reset release.

State machine (registered; all transitions on the rising clk edge):
- Priority 1, every state: if pwr = 0, go to IDLE.
- IDLE:
  - trg & arm → PREALARM; load counter = DELAY_CYC-1.
  - trg & !arm → CHIME.
- PREALARM:
  - !trg → IDLE (correct code entered in time).
  - Otherwise, if counter = 0 → SIREN; load counter = SIREN_CYC-1; alarm_count_o += 1, saturating at 15.
  - Otherwise decrement the counter.
- SIREN:
  - !trg → IDLE.
  - Otherwise, silence_i = 1 or counter = 0 → HOLDOFF.
  - Otherwise decrement the counter.
  - If silence_i and timeout coincide, go to HOLDOFF (same result either way).
- HOLDOFF: !trg → IDLE; otherwise stay. The siren does not re-arm until trg clears.
- CHIME:
  - !trg → IDLE.
  - arm & trg → PREALARM; load counter = DELAY_CYC-1.
- silence_i is ignored in every state except SIREN.

Outputs by state:
- siren_o = 1 only in SIREN.
- led_alert_o: 0 in IDLE; blink phase in PREALARM and CHIME; 1 in SIREN and HOLDOFF.

Latency:
- A trigger at status_i sampled at edge N is in stat_s after edge N+1; the state becomes PREALARM after edge N+2.
- siren_o rises after edge N+2+DELAY_CYC.
- siren_o stays high for at most SIREN_CYC cycles.

Reset mid-operation: immediate return to the reset values; the in-flight delay or siren is abandoned.

Optional Feature:
- Macro: SIREN_PULSE_EN.
- Defined: in SIREN, siren_o = blink phase (pulsed tone); all other behaviour unchanged.
- Undefined: siren_o is steady 1 throughout SIREN.

Test Plan:
- Reset release, status_i = 3'b100 for 10 cycles → led_power_o = 1 from edge 2; siren_o = 0, led_alert_o = 0, alarm_count_o = 0.
- status_i = 3'b111 held (DELAY_CYC = 16) → PREALARM with led_alert_o blinking every 4 cycles; siren_o rises after edge 18 from the change; alarm_count_o = 1.
- Armed trigger, then status_i = 3'b110 after 8 cycles → return to IDLE; siren_o never asserts; alarm_count_o unchanged.
- Siren active, silence_i pulsed for 1 cycle → siren_o = 0 next edge, led_alert_o stays 1 (HOLDOFF). Then status_i = 3'b110 → led_alert_o = 0 two edges later.
- Siren with no silence, SIREN_CYC = 64 → siren_o high exactly 64 cycles, then HOLDOFF. Repeat arm/trigger 17 times → alarm_count_o saturates at 15.
- status_i = 3'b101 (unlocked trigger) → CHIME, blink, no siren; then status_i = 3'b000 → IDLE. rst_n asserted mid-SIREN → siren_o = 0 immediately (asynchronous).
